// File: rtl/timing_leak_monitor.sv
// timing_leak_monitor: constant-time checker for NCH sequential multipliers
// that share one start pulse. Each channel's first done is timestamped from
// start, and at the end of a run the spread of latencies (or a timeout) is
// reported as a timing leak.
//
// Optional build macro: TIMING_LEAK_STICKY_EN
//   defined     -> leak stays 1 after the first leaking run until rst
//   not defined -> leak reflects only the most recent run
//
// Handshake: start is a single-cycle request, sampled only in IDLE. Done
// inputs are level-sampled; only the first high sample per channel per run
// counts. reportValid is a one-cycle strobe, and the result outputs hold
// their values until the next strobe. There is no back-pressure.
//
// dbgState exposes the FSM state for checkers (0=IDLE, 1=RUN, 2=REPORT).
module timing_leak_monitor #(
  parameter int NCH       = 2,
  parameter int CNT_WIDTH = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NCH-1:0]       done,
  output logic                 busy,
  output logic                 doneAny,
  output logic                 reportValid,
  output logic                 leak,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] minLatency,
  output logic [CNT_WIDTH-1:0] maxLatency,
  output logic [CNT_WIDTH-1:0] skew,
  output logic [15:0]          leakCount,
  output logic [1:0]           dbgState
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } stateT;

  stateT                state;
  stateT                stateNext;
  logic [CNT_WIDTH-1:0] counter;
  logic [NCH-1:0]       flags;
  logic [CNT_WIDTH-1:0] lat [NCH];

  logic [NCH-1:0]       captureNow;
  logic [NCH-1:0]       flagsNext;
  logic                 allDone;
  logic                 atTimeout;
  logic                 finishRun;
  logic [CNT_WIDTH-1:0] effLat [NCH];
  logic [CNT_WIDTH-1:0] runMin;
  logic [CNT_WIDTH-1:0] runMax;
  logic [CNT_WIDTH-1:0] runSkew;
  logic                 runTimeout;
  logic                 runLeak;

  assign dbgState = state;

  // Capture bookkeeping and next-state selection for the current cycle.
  always_comb begin
    captureNow = '0;
    if (state == RUN) captureNow = done & ~flags;
    flagsNext = flags | captureNow;
    allDone   = &flagsNext;
    atTimeout = (counter == TIMEOUT_C);
    finishRun = (state == RUN) && (allDone || atTimeout);
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (allDone || atTimeout) stateNext = REPORT;
      REPORT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Final latencies as they stand after this cycle's captures; channels that
  // never finished are charged the full timeout.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      if (captureNow[i])  effLat[i] = counter;
      else if (flags[i])  effLat[i] = lat[i];
      else                effLat[i] = TIMEOUT_C;
    end
    runMin = effLat[0];
    runMax = effLat[0];
    for (int i = 1; i < NCH; i++) begin
      if (effLat[i] < runMin) runMin = effLat[i];
      if (effLat[i] > runMax) runMax = effLat[i];
    end
    runSkew = runMax - runMin;
    // A run only ends without all flags set when the timeout fired.
    runTimeout = ~allDone;
    runLeak    = (runSkew != '0) | runTimeout;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Cycle counter, capture flags and per-channel latency registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      flags   <= '0;
      for (int i = 0; i < NCH; i++) lat[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        counter <= CNT_WIDTH'(1);
        flags   <= '0;
      end else if (state == RUN) begin
        flags <= flagsNext;
        for (int i = 0; i < NCH; i++) begin
          if (captureNow[i]) lat[i] <= counter;
        end
        // Hold at the end of a run so a TIMEOUT of 2^CNT_WIDTH-1 cannot wrap.
        if (!finishRun) counter <= counter + CNT_WIDTH'(1);
      end
    end
  end

  // Registered status and result outputs; results load only when a run ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      doneAny     <= 1'b0;
      reportValid <= 1'b0;
      leak        <= 1'b0;
      timeout     <= 1'b0;
      minLatency  <= '0;
      maxLatency  <= '0;
      skew        <= '0;
      leakCount   <= '0;
    end else begin
      busy        <= (stateNext == RUN);
      doneAny     <= (state == RUN) && (stateNext == RUN) && (|flagsNext);
      reportValid <= finishRun;
      if (finishRun) begin
        minLatency <= runMin;
        maxLatency <= runMax;
        skew       <= runSkew;
        timeout    <= runTimeout;
`ifdef TIMING_LEAK_STICKY_EN
        leak       <= leak | runLeak;
`else
        leak       <= runLeak;
`endif
        if (runLeak && leakCount != 16'hFFFF) leakCount <= leakCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_timing_leak_monitor.sv
// Bench for timing_leak_monitor (NCH=2, CNT_WIDTH=8, TIMEOUT=10). Each
// scenario task drives a run, pushes the expected report into exp_q and pops
// it when reportValid strobes.
module tb_timing_leak_monitor;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int TO  = 10;
  localparam int W   = 2 + 3 * CW + 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NCH-1:0] done = '0;
  logic          busy, doneAny, reportValid, leak, timeout;
  logic [CW-1:0] minLatency, maxLatency, skew;
  logic [15:0]   leakCount;
  logic [1:0]    dbgState;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  int mdlLeakCount = 0;
  bit mdlLeak      = 1'b0;

  timing_leak_monitor #(.NCH(NCH), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .busy(busy), .doneAny(doneAny), .reportValid(reportValid),
    .leak(leak), .timeout(timeout), .minLatency(minLatency),
    .maxLatency(maxLatency), .skew(skew), .leakCount(leakCount),
    .dbgState(dbgState)
  );

  // clock
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run one measurement. l0/l1: cycle at which each channel first raises
  // done (0 = never). tog0 toggles done[0] after capture; startRun pulses
  // start mid-run; startRep pulses start during REPORT.
  task automatic do_run(input int l0, input int l1, input bit tog0,
                        input bit startRun, input bit startRep, input string nm);
    int e0, e1, emin, emax, first, c;
    bit eto, eleak, got;
    logic [W-1:0] ex, ob;
    e0  = (l0 == 0 || l0 > TO) ? TO : l0;
    e1  = (l1 == 0 || l1 > TO) ? TO : l1;
    eto = (l0 == 0 || l0 > TO) || (l1 == 0 || l1 > TO);
    emin = (e0 < e1) ? e0 : e1;
    emax = (e0 > e1) ? e0 : e1;
    eleak = (emax != emin) || eto;
    if (eleak && mdlLeakCount < 16'hFFFF) mdlLeakCount++;
`ifdef TIMING_LEAK_STICKY_EN
    mdlLeak = mdlLeak | eleak;
`else
    mdlLeak = eleak;
`endif
    first = 0;
    if (l0 != 0 && l0 <= TO) first = l0;
    if (l1 != 0 && l1 <= TO && (first == 0 || l1 < first)) first = l1;
    exp_q.push_back({mdlLeak, eto, CW'(emin), CW'(emax), CW'(emax - emin),
                     16'(mdlLeakCount)});

    start = 1'b1;
    cyc();
    start = 1'b0;
    got = 1'b0;
    c = 1;
    while (c <= TO + 2 && !got) begin
      done[0] = (l0 != 0) && (tog0 ? (c == l0 || (c > l0 && c[0])) : (c >= l0));
      done[1] = (l1 != 0) && (c >= l1);
      start   = startRun && (c == 2);
      cyc();
      if (reportValid) begin
        got = 1'b1;
        ex = exp_q.pop_front();
        ob = {leak, timeout, minLatency, maxLatency, skew, leakCount};
        total++;
        if (ob !== ex) begin
          bad++;
          $display("FAIL %s report: got leak=%0b to=%0b min=%0d max=%0d skew=%0d cnt=%0d, want leak=%0b to=%0b min=%0d max=%0d skew=%0d cnt=%0d",
                   nm, ob[W-1], ob[W-2], ob[3*CW+15:2*CW+16], ob[2*CW+15:CW+16],
                   ob[CW+15:16], ob[15:0], ex[W-1], ex[W-2], ex[3*CW+15:2*CW+16],
                   ex[2*CW+15:CW+16], ex[CW+15:16], ex[15:0]);
        end
        total++;
        if ({busy, doneAny} !== 2'b00) begin
          bad++;
          $display("FAIL %s report_status: busy/doneAny got %b want 00", nm, {busy, doneAny});
        end
      end else begin
        total++;
        if ({busy, doneAny} !== {1'b1, (first != 0 && c >= first)}) begin
          bad++;
          $display("FAIL %s run_status c=%0d: busy/doneAny got %b want %b", nm, c,
                   {busy, doneAny}, {1'b1, (first != 0 && c >= first)});
        end
      end
      c++;
    end
    start = 1'b0;
    done  = '0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s no_report: reportValid never seen within %0d cycles", nm, TO + 2);
      void'(exp_q.pop_front());
    end
    // Cycle after REPORT: back in IDLE, strobe gone, results held.
    start = startRep;
    cyc();
    start = 1'b0;
    total++;
    if ({reportValid, busy, minLatency} !== {2'b00, CW'(emin)}) begin
      bad++;
      $display("FAIL %s after_report: rv/busy/min got %b/%b/%0d want 0/0/%0d", nm,
               reportValid, busy, minLatency, emin);
    end
    cyc();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_hold: busy got %b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    done = '1;
    cyc();
    cyc();
    total++;
    if ({busy, doneAny, reportValid, leak, timeout, minLatency, maxLatency, skew, leakCount, dbgState} !== '0) begin
      bad++;
      $display("FAIL reset_state: outputs got busy=%b rv=%b leak=%b min=%0d cnt=%0d want all 0",
               busy, reportValid, leak, minLatency, leakCount);
    end
    rst = 1'b0;
    cyc();
    cyc();
    done = '0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_done: busy got %b want 0 (done ignored in IDLE)", busy);
    end
  endtask

  task automatic test_match();      do_run(5, 5, 0, 0, 0, "match");      endtask
  task automatic test_skew();       do_run(4, 7, 0, 0, 0, "skew");       endtask
  task automatic test_timeout();    do_run(3, 0, 0, 0, 0, "timeout");    endtask
  task automatic test_first_cycle(); do_run(1, 1, 0, 0, 0, "first_cycle"); endtask
  task automatic test_ignore();     do_run(2, 6, 1, 1, 1, "ignore");     endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      int a, b;
      a = $urandom_range(1, TO);
      b = ($urandom_range(0, 1) == 1) ? a : $urandom_range(1, TO);
      do_run(a, b, 0, 0, 0, "b2b");
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c < 6; c++) cyc();
    rst = 1'b1;
    #1;
    total++;
    if ({busy, doneAny, reportValid, leak, timeout, minLatency, maxLatency, skew, leakCount} !== '0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b leak=%b min=%0d cnt=%0d want all 0",
               busy, leak, minLatency, leakCount);
    end
    cyc();
    rst = 1'b0;
    mdlLeakCount = 0;
    mdlLeak = 1'b0;
    cyc();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_idle: busy got %b want 0", busy);
    end
    do_run(2, 2, 0, 0, 0, "fresh");
  endtask

  task automatic test_sticky();
    do_run(1, 3, 0, 0, 0, "sticky_mis");
    do_run(6, 6, 0, 0, 0, "sticky_match");
  endtask

  initial begin
    test_reset();
    test_match();
    test_skew();
    test_timeout();
    test_first_cycle();
    test_ignore();
    test_back_to_back();
    test_mid_reset();
    test_sticky();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timing_leak_monitor.md
Name: timing_leak_monitor

Overview:
- N-channel constant-time checker for sequential multipliers.
- NCH multiplier instances share one start pulse. This block times each channel's done from start and compares the latencies.
- Any mismatch or timeout is reported as a timing leak.
- Sits beside the multiplier instances in the tester, replacing per-pair combinational done comparison with measured latency, skew and a leak counter.

Parameters:
- NCH, 2, number of monitored channels (2..16).
- CNT_WIDTH, 8, width of cycle counter and latency/skew outputs.
- TIMEOUT, 200, max cycles to wait for all dones. Must satisfy 1 <= TIMEOUT <= 2^CNT_WIDTH-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; same signal drives all multiplier instances.
- done  input  NCH  per-channel productDone, level-sampled.
- busy  output  1  high while measuring.
- doneAny  output  1  high in RUN once at least one channel has finished.
- reportValid  output  1  one-cycle pulse; result outputs updated this cycle.
- leak  output  1  latencies not all equal, or timeout.
- timeout  output  1  TIMEOUT reached before all channels finished.
- minLatency  output  CNT_WIDTH  smallest channel latency of last run.
- maxLatency  output  CNT_WIDTH  largest channel latency of last run.
- skew  output  CNT_WIDTH  maxLatency - minLatency.
- leakCount  output  16  number of leaking runs since reset, saturating at 16'hFFFF.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, counter 0, capture flags and latency registers 0.
- States: IDLE, RUN, REPORT. All outputs are registered.
- IDLE:
  - start=1 at an edge moves to RUN, sets counter to 1, and clears all capture flags.
  - done is ignored in IDLE.
- RUN (busy=1):
  - Each cycle, for every channel with done[i]=1 and flag clear: latency[i]=counter, flag set.
  - Later done pulses or levels on a captured channel are ignored.
  - start is ignored in RUN.
  - doneAny=1 from the cycle after the first capture until RUN exits.
  - All flags set (including captures this cycle): go to REPORT.
  - Else if counter==TIMEOUT: go to REPORT with timeout condition.
  - Else counter+1.
- Timeout: uncaptured channels take latency=TIMEOUT.
- REPORT: one cycle; busy=0, doneAny=0, reportValid=1.
  - minLatency/maxLatency/skew computed over all NCH latencies.
  - leak=(skew!=0)|timeout.
  - leakCount increments if leak, saturating.
  - Next state is always IDLE; start in REPORT is ignored.
- Result outputs hold their value until the next REPORT. reportValid returns to 0 after REPORT.
- Simultaneous capture of all channels in the first RUN cycle gives latency 1 and skew 0.
- Reset mid-RUN aborts the run. No report is produced; leakCount is cleared.
- Width: latencies never exceed TIMEOUT, so the counter never wraps.

Optional Feature:
- TIMING_LEAK_STICKY_EN defined: leak is sticky. Once set in any REPORT, it stays 1 until rst, even if later runs match. timeout and skew still update per run.
- Not defined: leak is recomputed at every REPORT and reflects only the last run.

Test Plan:
- NCH=2, start; both done at counter 5 -> REPORT next cycle: min=max=5, skew=0, leak=0, leakCount=0.
- NCH=2, done[0] at 4, done[1] at 7 -> doneAny=1 from cycle 5; REPORT: min=4, max=7, skew=3, leak=1, leakCount=1.
- TIMEOUT=10; done[1] never asserts, done[0] at 3 -> REPORT after counter 10: timeout=1, leak=1, min=3, max=10, skew=7.
- start pulsed again during RUN and during REPORT; done[0] toggles after capture -> ignored; latencies unchanged; exactly one reportValid pulse per accepted start.
- rst asserted mid-RUN at counter 6 -> immediately busy=0, all outputs 0; new start gives a fresh measurement from counter 1.
- Mismatched run, then matched run -> without macro leak=1 then 0; with TIMING_LEAK_STICKY_EN leak stays 1. leakCount=1 in both builds.
